// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/halfword/word loads and stores into a 2^WORD_AW x 32-bit array.
// Latency: request accepted from IDLE; ready pulses in the second cycle after the accepting edge.
// Backpressure: none; requests are sampled only in IDLE and ignored in BUSY/DONE (one access per 3 cycles).
module data_mem_ctrl #(
    parameter int WORD_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEPTH = 1 << WORD_AW;

    // Request captured at the accepting edge; all decode works from this copy.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdat;
    } req_t;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    req_t               req_q;
    logic               accept;

    logic [31:0]        mem [0:DEPTH-1];
    logic [WORD_AW-1:0] widx;

    logic               is_b;
    logic               is_h;
    logic               is_w;
    logic               is_bu;
    logic               is_hu;
    logic               f3_legal;
    logic               acc_err;

    logic [3:0]         be;
    logic [31:0]        wlane;
    logic               commit_we;

    logic [31:0]        rword;
    logic [7:0]         rbyte;
    logic [15:0]        rhalf;
    logic [31:0]        load_val;

    // Upper address bits beyond the storage window are deliberately ignored (address wraps).
    logic               unused_addr_hi;
    assign unused_addr_hi = ^req_q.addr[31:WORD_AW+2];

    assign accept = (state == IDLE) && (MemRead || MemWrite);
    assign widx   = req_q.addr[WORD_AW+1:2];
    assign ready  = (state == DONE);

    // Next-state: IDLE waits for a request, BUSY and DONE each last exactly one cycle.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? BUSY : IDLE;
            BUSY:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and request latch; reset drops any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q <= {MemRead, MemWrite, funct3, addr, wdata};
            end
        end
    end

    // Access size/sign decode from the latched funct3.
    always_comb begin
        is_b     = 1'b0;
        is_h     = 1'b0;
        is_w     = 1'b0;
        is_bu    = 1'b0;
        is_hu    = 1'b0;
        f3_legal = 1'b1;
        case (req_q.f3)
            3'b000:  is_b     = 1'b1;
            3'b001:  is_h     = 1'b1;
            3'b010:  is_w     = 1'b1;
            3'b100:  is_bu    = 1'b1;
            3'b101:  is_hu    = 1'b1;
            default: f3_legal = 1'b0;
        endcase
    end

    // Error classification: conflicting request, unknown size, unsigned store, misalignment.
    always_comb begin
        acc_err = 1'b0;
        if (req_q.rd && req_q.wr) begin
            acc_err = 1'b1;
        end
        if (!f3_legal) begin
            acc_err = 1'b1;
        end
        if ((is_bu || is_hu) && req_q.wr) begin
            acc_err = 1'b1;
        end
        if ((is_h || is_hu) && req_q.addr[0]) begin
            acc_err = 1'b1;
        end
        if (is_w && (req_q.addr[1:0] != 2'b00)) begin
            acc_err = 1'b1;
        end
    end

    // Store lane steering: replicate the LSB-aligned data across lanes, enable only the target ones.
    always_comb begin
        be    = 4'b0000;
        wlane = 32'h0000_0000;
        if (is_b) begin
            be    = 4'b0001 << req_q.addr[1:0];
            wlane = {4{req_q.wdat[7:0]}};
        end else if (is_h) begin
            be    = req_q.addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{req_q.wdat[15:0]}};
        end else if (is_w) begin
            be    = 4'b1111;
            wlane = req_q.wdat;
        end
    end

    assign commit_we = (state == BUSY) && req_q.wr && !acc_err;

    // Storage write at the edge leaving BUSY; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst && commit_we) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n]) begin
                    mem[widx][8*n +: 8] <= wlane[8*n +: 8];
                end
            end
        end
    end

    assign rword = mem[widx];
    assign rhalf = req_q.addr[1] ? rword[31:16] : rword[15:0];

    // Byte lane select for loads (lane n is bits [8n+7:8n]).
    always_comb begin
        rbyte = rword[7:0];
        case (req_q.addr[1:0])
            2'd0: rbyte = rword[7:0];
            2'd1: rbyte = rword[15:8];
            2'd2: rbyte = rword[23:16];
            2'd3: rbyte = rword[31:24];
            default: rbyte = rword[7:0];
        endcase
    end

    // Load extension: signed forms replicate the top bit, unsigned forms pad with zeros.
    always_comb begin
        load_val = 32'h0000_0000;
        if (is_b) begin
            load_val = {{24{rbyte[7]}}, rbyte};
        end else if (is_bu) begin
            load_val = {24'h0, rbyte};
        end else if (is_h) begin
            load_val = {{16{rhalf[15]}}, rhalf};
        end else if (is_hu) begin
            load_val = {16'h0, rhalf};
        end else if (is_w) begin
            load_val = rword;
        end
    end

    // Completion result captured leaving BUSY and held until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'h0000_0000;
            err   <= 1'b0;
        end else if (state == BUSY) begin
            err   <= acc_err;
            rdata <= (req_q.rd && !acc_err) ? load_val : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed spec scenarios plus randomized traffic.
// Expected completions are queued at issue time and matched by an independent ready monitor.
// Reference storage is a flat byte array with little-endian assembly and modulo addressing.
module tb_data_mem_ctrl;

    localparam int AW     = 10;
    localparam int NBYTES = 4 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    data_mem_ctrl #(.WORD_AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] ref_mem [NBYTES];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_ready  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference behaviour of one access; updates the byte array for legal stores.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rv, output logic e);
        int          base;
        int          size;
        logic        sgn;
        logic [31:0] val;
        base = int'(a & 32'(NBYTES - 1));
        size = 0;
        sgn  = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b0; end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd5: begin size = 2; sgn = 1'b0; end
            default: size = 0;
        endcase
        e = (rd && wr) || (size == 0);
        if (wr && (f3 == 3'd4 || f3 == 3'd5)) e = 1'b1;
        if (size != 0 && (base % size) != 0) e = 1'b1;
        rv = 32'h0;
        if (!e && wr) begin
            for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
        end
        if (!e && rd) begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val |= 32'(ref_mem[base + i]) << (8 * i);
            if (sgn && val[8*size-1]) val |= 32'hFFFF_FFFF << (8 * size);
            rv = val;
        end
    endfunction

    // Issue one access from IDLE; junk is driven while BUSY/DONE, where it must be ignored.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic use_k, input logic [31:0] k_rdata, input logic k_err);
        exp_t        e;
        logic [31:0] rv;
        logic        er;
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        model(rd, wr, f3, a, wd, rv, er);
        e.rdata = use_k ? k_rdata : rv;
        e.err   = use_k ? k_err   : er;
        e.cyc   = cyc + 2;
        sb.push_back(e);
        repeat (2) begin
            @(negedge clk);
            MemRead  = 1'($urandom);
            MemWrite = 1'($urandom);
            funct3   = 3'($urandom);
            addr     = $urandom;
            wdata    = $urandom;
        end
    endtask

    task automatic acc_m(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        access(rd, wr, f3, a, wd, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic acc_k(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] k_rdata, input logic k_err);
        access(rd, wr, f3, a, wd, 1'b1, k_rdata, k_err);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            n_ready++;
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", rdata, mon_e.rdata);
                chk("err", 32'(err), 32'(mon_e.err));
                chk("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        exp_t        e;
        logic [31:0] rv;
        logic        er;
        logic [31:0] a;
        int          r0;
        int          kind;

        rst      = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct3   = 3'b000;
        addr     = 32'h0;
        wdata    = 32'h0;
        #1;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fill storage so every later load has a defined reference value.
        for (int w = 0; w < (1 << AW); w++) acc_m(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom);

        // Word store/load round trip.
        acc_k(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        acc_k(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store, signed/unsigned byte loads, word view of the lanes.
        acc_k(1'b0, 1'b1, 3'b000, 32'h13, 32'h80, 32'h0, 1'b0);
        acc_k(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        acc_k(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        acc_k(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

        // Halfword store/load and a misaligned unsigned halfword load.
        acc_k(1'b0, 1'b1, 3'b001, 32'h12, 32'h1234, 32'h0, 1'b0);
        acc_k(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0);
        acc_k(1'b1, 1'b0, 3'b101, 32'h11, 32'h0, 32'h0, 1'b1);
        acc_k(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

        // Conflicting request and unsigned-size store must not touch storage.
        acc_k(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1);
        acc_k(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        acc_k(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

        // Address wrap modulo 2^(AW+2) bytes.
        acc_k(1'b0, 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0);
        acc_k(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset during BUSY cancels a store; a request held through reset is taken right after.
        acc_k(1'b0, 1'b1, 3'b010, 32'h20, 32'hAAAAAAAA, 32'h0, 1'b0);
        acc_k(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hAAAAAAAA, 1'b0);
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h20;
        wdata    = 32'h55555555;
        @(negedge clk);
        rst      = 1'b1;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        wdata    = 32'h0;
        #1;
        chk("midreset_rdata", rdata, 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        chk("midreset_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rv, er);
        e.rdata = 32'hAAAAAAAA;
        e.err   = 1'b0;
        e.cyc   = cyc + 2;
        sb.push_back(e);
        @(negedge clk);
        MemRead = 1'b0;
        @(negedge clk);

        // Load held high for 9 cycles: three completions, three cycles apart.
        @(negedge clk);
        a        = 32'(4 * $urandom_range(0, (1 << AW) - 1));
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        funct3   = 3'b010;
        addr     = a;
        model(1'b1, 1'b0, 3'b010, a, 32'h0, rv, er);
        r0 = n_ready;
        for (int k = 0; k < 3; k++) begin
            e.rdata = rv;
            e.err   = er;
            e.cyc   = cyc + 2 + 3 * k;
            sb.push_back(e);
        end
        repeat (9) @(negedge clk);
        MemRead = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_ready_count", 32'(n_ready - r0), 32'd3);

        // Randomized mix of loads, stores, conflicts, illegal sizes and misaligned addresses.
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            acc_m(kind < 5, (kind >= 5) || (kind == 0 && $urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), a, $urandom);
        end

        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
